// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and default widths for the memory request controller.
package mem_req_ctrl_pkg;
  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 8;

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_e;
  typedef enum logic {REQ_IF = 1'b0, REQ_LS = 1'b1} req_id_e;
endpackage

// File: rtl/mem_req_arb.sv
// Fetch vs load/store arbiter: data wins by default; a fetch wins once
// FAIR_MAX consecutive data grants have gone by while it was waiting.
module mem_req_arb
  import mem_req_ctrl_pkg::*;
#(
  parameter int FAIR_MAX = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       if_req_i,
  input  logic       ls_req_i,
  output req_id_e    win_o,
  output logic [1:0] gnt_o
);
  localparam int FW = (FAIR_MAX < 1) ? 1 : $clog2(FAIR_MAX + 1);

  logic [FW-1:0] fair_q;
  logic          fetch_first;

  always_comb begin
    fetch_first = if_req_i && (!ls_req_i || (fair_q == FW'(FAIR_MAX)));
    win_o       = fetch_first ? REQ_IF : REQ_LS;
    gnt_o       = 2'b00;
    if (en_i) begin
      if (fetch_first)   gnt_o = 2'b01;
      else if (ls_req_i) gnt_o = 2'b10;
    end
  end

  // Counts data grants that a waiting fetch has watched go past.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    fair_q <= '0;
    else if (!if_req_i || gnt_o[0])                fair_q <= '0;
    else if (gnt_o[1] && fair_q != FW'(FAIR_MAX))  fair_q <= fair_q + 1'b1;
  end
endmodule

// File: rtl/mem_req_ctrl.sv
// Memory request controller: arbitrates fetch/load-store, issues one access
// per grant, waits RD_LAT cycles for reads. MEM_REQ_PERF_CNT_EN adds stall_cnt.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int AWIDTH   = AWIDTH_DEF,
  parameter int RD_LAT   = 1,
  parameter int FAIR_MAX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DWIDTH-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [AWIDTH-1:0] ls_addr,
  input  logic [DWIDTH-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DWIDTH-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_REQ_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  state_e            state_q;
  logic [1:0]        lat_q;
  req_id_e           id_q;
  logic              if_rvalid_q, ls_rvalid_q;
  logic [DWIDTH-1:0] if_rdata_q, ls_rdata_q;
  logic [1:0]        gnt;
  req_id_e           win;
  logic              rd_start;

  mem_req_arb #(.FAIR_MAX(FAIR_MAX)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (state_q == IDLE),
    .if_req_i (if_req),
    .ls_req_i (ls_req),
    .win_o    (win),
    .gnt_o    (gnt)
  );

  assign if_gnt = gnt[0];
  assign ls_gnt = gnt[1];

  always_comb begin
    mem_en    = |gnt;
    mem_we    = gnt[1] & ls_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[1]) begin
      mem_addr = ls_addr;
      if (ls_we) mem_wdata = ls_wdata;
    end else if (gnt[0]) begin
      mem_addr = if_addr;
    end
  end

  assign rd_start = mem_en && !mem_we;

  // lat_q counts RD_WAIT cycles; mem_rdata is sampled in the last of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      id_q        <= REQ_IF;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_start) begin
            state_q <= RD_WAIT;
            lat_q   <= '0;
            id_q    <= win;
          end
        end
        RD_WAIT: begin
          if (lat_q == 2'(RD_LAT - 1)) begin
            state_q <= IDLE;
            if (id_q == REQ_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata;
            end else begin
              ls_rvalid_q <= 1'b1;
              ls_rdata_q  <= mem_rdata;
            end
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign busy      = (state_q == RD_WAIT);

`ifdef MEM_REQ_PERF_CNT_EN
  logic [15:0] stall_q;
  logic        stall;

  assign stall = (if_req && !if_gnt) || (ls_req && !ls_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             stall_q <= '0;
    else if (stall && stall_q != 16'hFFFF)  stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench: one controller with RD_LAT=1 (a_*) and one with RD_LAT=3 (b_*).
module tb_mem_req_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic        ls_req = 1'b0, ls_we = 1'b0;
  logic [7:0]  ls_addr = '0;
  logic [15:0] ls_wdata = '0;

  logic        a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_mem_en, a_mem_we, a_busy;
  logic [15:0] a_if_rdata, a_ls_rdata, a_mem_wdata, a_mem_rdata;
  logic [7:0]  a_mem_addr;
  logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [15:0] b_if_rdata, b_ls_rdata, b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_mem_addr;
`ifdef MEM_REQ_PERF_CNT_EN
  logic [15:0] a_stall, b_stall;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_req_ctrl #(.DWIDTH(16), .AWIDTH(8), .RD_LAT(1), .FAIR_MAX(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(a_ls_gnt), .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
`ifdef MEM_REQ_PERF_CNT_EN
    , .stall_cnt(a_stall)
`endif
  );

  mem_req_ctrl #(.DWIDTH(16), .AWIDTH(8), .RD_LAT(3), .FAIR_MAX(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
`ifdef MEM_REQ_PERF_CNT_EN
    , .stall_cnt(b_stall)
`endif
  );

  // Memory models: unwritten words read as {addr+8'h30, 8'h00}; data outside
  // the valid window reads as 16'hDEAD.
  logic [15:0] mema [256], memb [256];
  logic        wva [256], wvb [256];
  logic [15:0] a_rd1, b_p1, b_p2, b_p3;

  function automatic logic [15:0] dflt(input logic [7:0] ad);
    logic [7:0] hi;
    hi = ad + 8'h30;
    return {hi, 8'h00};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        wva[i] <= 1'b0;
        wvb[i] <= 1'b0;
      end
    end else begin
      if (a_mem_en && a_mem_we) begin
        mema[a_mem_addr] <= a_mem_wdata;
        wva[a_mem_addr]  <= 1'b1;
      end
      if (b_mem_en && b_mem_we) begin
        memb[b_mem_addr] <= b_mem_wdata;
        wvb[b_mem_addr]  <= 1'b1;
      end
    end
    a_rd1 <= (a_mem_en && !a_mem_we) ? (wva[a_mem_addr] ? mema[a_mem_addr] : dflt(a_mem_addr)) : 16'hDEAD;
    b_p1  <= (b_mem_en && !b_mem_we) ? (wvb[b_mem_addr] ? memb[b_mem_addr] : dflt(b_mem_addr)) : 16'hDEAD;
    b_p2  <= b_p1;
    b_p3  <= b_p2;
  end

  assign a_mem_rdata = a_rd1;
  assign b_mem_rdata = b_p3;

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    mid();
    total++;
    if ({a_if_gnt, a_if_rvalid, a_if_rdata, a_ls_gnt, a_ls_rvalid, a_ls_rdata,
         a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_busy} !== '0) begin
      bad++; $display("FAIL reset_outs_a: got busy=%0b mem_en=%0b if_rdata=%h want all 0", a_busy, a_mem_en, a_if_rdata);
    end
    total++;
    if ({b_if_gnt, b_if_rvalid, b_if_rdata, b_ls_gnt, b_ls_rvalid, b_ls_rdata,
         b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_busy} !== '0) begin
      bad++; $display("FAIL reset_outs_b: got busy=%0b mem_en=%0b want all 0", b_busy, b_mem_en);
    end
`ifdef MEM_REQ_PERF_CNT_EN
    total++;
    if (a_stall !== 16'h0) begin bad++; $display("FAIL reset_stall: got %h want 0000", a_stall); end
`endif
  endtask

  task automatic single_fetch(input string tag);
    if_req = 1'b1; if_addr = 8'h04;
    mid();
    total++;
    if ({a_if_gnt, a_ls_gnt, a_mem_en, a_mem_we, a_mem_addr, a_busy} !== {4'b1010, 8'h04, 1'b0}) begin
      bad++; $display("FAIL %s_T: got gnt=%0b en=%0b we=%0b addr=%h busy=%0b want 1 1 0 04 0",
                      tag, a_if_gnt, a_mem_en, a_mem_we, a_mem_addr, a_busy);
    end
    adv(); if_req = 1'b0;
    mid();
    total++;
    if ({a_busy, a_if_rvalid, a_mem_en} !== 3'b100) begin
      bad++; $display("FAIL %s_T1: got busy=%0b rvalid=%0b en=%0b want 1 0 0", tag, a_busy, a_if_rvalid, a_mem_en);
    end
    adv(); mid();
    total++;
    if ({a_if_rvalid, a_if_rdata, a_busy} !== {1'b1, 16'h3400, 1'b0}) begin
      bad++; $display("FAIL %s_T2: got rvalid=%0b rdata=%h busy=%0b want 1 3400 0", tag, a_if_rvalid, a_if_rdata, a_busy);
    end
    adv(); mid();
    total++;
    if ({a_if_rvalid, a_if_rdata} !== {1'b0, 16'h3400}) begin
      bad++; $display("FAIL %s_T3: got rvalid=%0b rdata=%h want 0 3400", tag, a_if_rvalid, a_if_rdata);
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    single_fetch("fetch");
  endtask

  task automatic test_store_load();
    do_reset();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'd100; ls_wdata = 16'h0032;
    mid();
    total++;
    if ({a_ls_gnt, a_if_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {4'b1011, 8'd100, 16'h0032}) begin
      bad++; $display("FAIL store_T: got gnt=%0b en=%0b we=%0b addr=%0d wdata=%h want 1 1 1 100 0032",
                      a_ls_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
    end
    adv(); ls_we = 1'b0;
    mid();
    total++;
    if ({a_ls_gnt, a_mem_en, a_mem_we, a_mem_addr, a_busy} !== {3'b110, 8'd100, 1'b0}) begin
      bad++; $display("FAIL load_T1: got gnt=%0b en=%0b we=%0b addr=%0d busy=%0b want 1 1 0 100 0",
                      a_ls_gnt, a_mem_en, a_mem_we, a_mem_addr, a_busy);
    end
    adv(); ls_req = 1'b0;
    mid();
    total++;
    if ({a_busy, a_ls_rvalid} !== 2'b10) begin
      bad++; $display("FAIL load_T2: got busy=%0b rvalid=%0b want 1 0", a_busy, a_ls_rvalid);
    end
    adv(); mid();
    total++;
    if ({a_ls_rvalid, a_ls_rdata, a_if_rvalid} !== {1'b1, 16'h0032, 1'b0}) begin
      bad++; $display("FAIL load_T3: got rvalid=%0b rdata=%h if_rvalid=%0b want 1 0032 0", a_ls_rvalid, a_ls_rdata, a_if_rvalid);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g [8];
    exp_g = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    do_reset();
    if_req = 1'b1; if_addr = 8'h08;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h60; ls_wdata = 16'h1234;
    for (int c = 0; c < 8; c++) begin
      mid();
      total++;
      if ({a_if_gnt, a_ls_gnt} !== exp_g[c]) begin
        bad++; $display("FAIL fair_c%0d: got if/ls=%b want %b", c, {a_if_gnt, a_ls_gnt}, exp_g[c]);
      end
      if (c == 2) begin
        total++;
        if ({a_mem_we, a_mem_addr} !== {1'b0, 8'h08}) begin
          bad++; $display("FAIL fair_fetch_addr: got we=%0b addr=%h want 0 08", a_mem_we, a_mem_addr);
        end
      end
      if (c == 4) begin
        total++;
        if ({a_if_rvalid, a_if_rdata} !== {1'b1, 16'h3800}) begin
          bad++; $display("FAIL fair_rvalid: got rvalid=%0b rdata=%h want 1 3800", a_if_rvalid, a_if_rdata);
        end
      end
      adv();
    end
    clear_inputs();
  endtask

  task automatic test_lat3_load();
    do_reset();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h20;
    mid();
    total++;
    if ({b_ls_gnt, b_mem_en, b_mem_addr} !== {2'b11, 8'h20}) begin
      bad++; $display("FAIL lat3_T: got gnt=%0b en=%0b addr=%h want 1 1 20", b_ls_gnt, b_mem_en, b_mem_addr);
    end
    adv(); ls_req = 1'b0; if_req = 1'b1; if_addr = 8'h07;
    for (int c = 1; c <= 3; c++) begin
      mid();
      total++;
      if ({b_if_gnt, b_ls_gnt, b_mem_en, b_busy, b_ls_rvalid} !== 5'b00010) begin
        bad++; $display("FAIL lat3_wait%0d: got gnt=%0b/%0b en=%0b busy=%0b rvalid=%0b want 0 0 0 1 0",
                        c, b_if_gnt, b_ls_gnt, b_mem_en, b_busy, b_ls_rvalid);
      end
      adv();
    end
    mid();
    total++;
    if ({b_ls_rvalid, b_ls_rdata, b_if_gnt, b_mem_addr, b_busy} !== {1'b1, 16'h5000, 1'b1, 8'h07, 1'b0}) begin
      bad++; $display("FAIL lat3_T4: got rvalid=%0b rdata=%h if_gnt=%0b addr=%h busy=%0b want 1 5000 1 07 0",
                      b_ls_rvalid, b_ls_rdata, b_if_gnt, b_mem_addr, b_busy);
    end
`ifdef MEM_REQ_PERF_CNT_EN
    total++;
    if (b_stall !== 16'd3) begin bad++; $display("FAIL stall_cnt: got %0d want 3", b_stall); end
`endif
    adv(); if_req = 1'b0;
    mid();
    total++;
    if ({b_ls_rvalid, b_ls_rdata} !== {1'b0, 16'h5000}) begin
      bad++; $display("FAIL lat3_hold: got rvalid=%0b rdata=%h want 0 5000", b_ls_rvalid, b_ls_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    int rv;
    do_reset();
    if_req = 1'b1; if_addr = 8'h04;
    mid();
    total++;
    if (a_if_gnt !== 1'b1) begin bad++; $display("FAIL rstmid_gnt: got %0b want 1", a_if_gnt); end
    adv(); if_req = 1'b0; rst_n = 1'b0;
    mid();
    total++;
    if ({a_if_gnt, a_if_rvalid, a_if_rdata, a_ls_gnt, a_ls_rvalid, a_ls_rdata,
         a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_busy} !== '0) begin
      bad++; $display("FAIL rstmid_outs: got busy=%0b rvalid=%0b en=%0b want all 0", a_busy, a_if_rvalid, a_mem_en);
    end
    adv(); adv(); rst_n = 1'b1;
    rv = 0;
    for (int c = 0; c < 3; c++) begin
      mid();
      if (a_if_rvalid === 1'b1 || a_busy === 1'b1) rv++;
      adv();
    end
    total++;
    if (rv !== 0) begin bad++; $display("FAIL rstmid_no_rvalid: got %0d active cycles want 0", rv); end
    single_fetch("refetch");
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_fairness();
    test_lat3_load();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
